// File: rtl/sync_pkg.sv
// Shared types and sizing helpers for the multi-channel synchroniser/debouncer.
package sync_pkg;

    typedef enum logic {STABLE, PENDING} deb_state_t;

    // Counter must hold values up to n without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_debounce_ch.sv
// One input channel: N-flop synchroniser, en-qualified debounce counter, registered edge pulses.
// q and rise/fall update on the same edge; o_commit is the combinational pre-register strobe.
module sync_debounce_ch
    import sync_pkg::*;
#(
    parameter int   STAGES          = 2,
    parameter int   DEBOUNCE_CYCLES = 3,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    input  logic en,
    output logic q,
    output logic rise,
    output logic fall,
    output logic o_commit
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

    logic [STAGES-1:0] r_sync;
    logic              w_s;
    deb_state_t        r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic              r_q, r_rise, r_fall;
    logic              w_commit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign w_s = r_sync[STAGES-1];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            STABLE: begin
                w_cnt_nxt = '0;
                if (w_s != r_q) begin
                    // A single-cycle debounce commits on the very first mismatch tick.
                    if (en && (DEBOUNCE_CYCLES == 1)) begin
                        w_commit = 1'b1;
                    end else begin
                        w_state_nxt = PENDING;
                        w_cnt_nxt   = en ? CW'(1) : '0;
                    end
                end
            end
            PENDING: begin
                if (w_s == r_q) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end else if (en) begin
                    if (r_cnt == LAST_CNT) begin
                        w_commit    = 1'b1;
                        w_state_nxt = STABLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= STABLE;
            r_cnt   <= '0;
            r_q     <= RESET_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rise  <= w_commit & w_s;
            r_fall  <= w_commit & ~w_s;
            if (w_commit) begin
                r_q <= w_s;
            end
        end
    end

    assign q        = r_q;
    assign rise     = r_rise;
    assign fall     = r_fall;
    assign o_commit = w_commit;

endmodule

// File: rtl/sync_debounce.sv
// WIDTH independent synchronise+debounce channels; changed is a registered OR of all edge pulses.
// Latency with en tied high: STAGES+DEBOUNCE_CYCLES edges from a stable d to q.
module sync_debounce
    import sync_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               STAGES          = 2,
    parameter int               DEBOUNCE_CYCLES = 3,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [WIDTH-1:0] w_commit;
    logic             r_changed;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        sync_debounce_ch #(
            .STAGES          (STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_VAL[gi])
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .d        (d[gi]),
            .en       (en),
            .q        (q[gi]),
            .rise     (rise[gi]),
            .fall     (fall[gi]),
            .o_commit (w_commit[gi])
        );
    end

    // Registered from the pre-register commit strobes so it lines up with rise/fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_commit;
        end
    end

    assign changed = r_changed;

endmodule

// File: tb/tb_sync_debounce.sv
// Randomised and directed stimulus for sync_debounce against a streak-count reference model.
module tb_sync_debounce;

    localparam int W   = 4;
    localparam int STG = 2;
    localparam int DEB = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] d = '0;
    logic         en = 1'b1;
    logic [W-1:0] q, rise, fall;
    logic         changed;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    logic [W-1:0] m_q, m_rise, m_fall;
    logic         m_chg;
    int           m_streak [W];
    logic [W-1:0] m_pipe [$];

    sync_debounce #(
        .WIDTH           (W),
        .STAGES          (STG),
        .DEBOUNCE_CYCLES (DEB),
        .RESET_VAL       ('0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .d       (d),
        .en      (en),
        .q       (q),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
        for (int i = 0; i < W; i++) m_streak[i] = 0;
        m_pipe.delete();
        for (int i = 0; i < STG; i++) m_pipe.push_back('0);
    endtask

    // Level seen by the debouncer at this edge is the d sampled STG edges earlier.
    task automatic model_step(input logic [W-1:0] dv, input logic ev);
        logic [W-1:0] s;
        s = m_pipe.pop_front();
        m_pipe.push_back(dv);
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < W; i++) begin
            if (s[i] != m_q[i]) begin
                if (ev) m_streak[i]++;
                if (m_streak[i] == DEB) begin
                    m_q[i] = s[i];
                    if (s[i]) m_rise[i] = 1'b1;
                    else      m_fall[i] = 1'b1;
                    m_streak[i] = 0;
                end
            end else begin
                m_streak[i] = 0;
            end
        end
        m_chg = |(m_rise | m_fall);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_q"},    32'(q),       32'(m_q));
        chk({tag, "_rise"}, 32'(rise),    32'(m_rise));
        chk({tag, "_fall"}, 32'(fall),    32'(m_fall));
        chk({tag, "_chg"},  32'(changed), 32'(m_chg));
        chk({tag, "_excl"}, 32'(rise & fall), 32'(0));
    endtask

    // Called at a negedge: drive inputs, take one posedge, check at the next negedge.
    task automatic cycle(input logic [W-1:0] dv, input logic ev, input string tag);
        d  = dv;
        en = ev;
        @(posedge clk);
        model_step(dv, ev);
        edge_n++;
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Asynchronous assertion mid-low-phase; outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        reset = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        logic [W-1:0] dv;
        logic [W-1:0] flip;
        logic         ev;

        model_reset();
        d = 4'b1010;
        @(negedge clk);
        @(negedge clk);
        check_outputs("rst_state");
        reset = 1'b0;
        edge_n = 0;

        // 1: reset exit with d already high on two channels
        for (int k = 0; k < 8; k++) begin
            cycle(4'b1010, 1'b1, "s1");
            if (edge_n == 4) chk("s1_q_edge4", 32'(q), 32'h0);
            if (edge_n == 5) begin
                chk("s1_q_edge5", 32'(q), 32'ha);
                chk("s1_rise_edge5", 32'(rise), 32'ha);
                chk("s1_chg_edge5", 32'(changed), 32'h1);
            end
            if (edge_n == 6) chk("s1_rise_edge6", 32'(rise), 32'h0);
        end

        // 2: short glitch on channel 0 is rejected
        cycle(4'b1011, 1'b1, "s2");
        cycle(4'b1011, 1'b1, "s2");
        for (int k = 0; k < 8; k++) cycle(4'b1010, 1'b1, "s2");
        chk("s2_q0_low", 32'(q[0]), 32'h0);

        // 3: channel 2 chatters then settles high
        for (int k = 0; k < 6; k++) cycle(4'b1010 ^ {1'b0, k[0] ? 1'b0 : 1'b1, 2'b00}, 1'b1, "s3");
        for (int k = 0; k < 8; k++) cycle(4'b1110, 1'b1, "s3");
        chk("s3_q2_high", 32'(q[2]), 32'h1);

        // 4: prescaled en, channel 1 falls
        for (int k = 0; k < 24; k++) cycle(4'b1100, (k % 4) == 3, "s4");
        chk("s4_q1_low", 32'(q[1]), 32'h0);

        // 5: reset while channel 0 is mid-count, then full latency again
        do_reset("s5_rst_a");
        for (int k = 0; k < 4; k++) cycle(4'b0001, 1'b1, "s5");
        do_reset("s5_rst_b");
        for (int k = 0; k < 6; k++) begin
            cycle(4'b0001, 1'b1, "s5b");
            if (edge_n == 4) chk("s5_q_edge4", 32'(q), 32'h0);
            if (edge_n == 5) chk("s5_q_edge5", 32'(q), 32'h1);
        end

        // 6: simultaneous rise on one channel and fall on another
        for (int k = 0; k < 6; k++) cycle(4'b1000, 1'b1, "s6a");
        chk("s6_q_start", 32'(q), 32'h8);
        for (int k = 0; k < 6; k++) begin
            cycle(4'b0010, 1'b1, "s6b");
            if (edge_n == 0) ;
        end
        chk("s6_q_end", 32'(q), 32'h2);

        // Random soak: sparse bit flips, random en, occasional reset.
        dv = d;
        for (int k = 0; k < 3000; k++) begin
            flip = '0;
            for (int i = 0; i < W; i++) flip[i] = ($urandom_range(0, 5) == 0);
            dv = dv ^ flip;
            ev = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
            cycle(dv, ev, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
